// File: rtl/riscv_wb_pkg.sv
// ----------------------------------------------------------------------------
// riscv_wb_pkg
// Shared definitions for the register-file writeback arbiter:
//   XLEN / REG_AW  data and register-address widths of the core
//   NUM_REGS       number of architectural registers (2**REG_AW)
//   wb_entry_t     one buffered long-latency result {rd, data}
//   starve_state_t states of the starvation-control FSM
// ----------------------------------------------------------------------------
package riscv_wb_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 2 ** REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // FIFO empty or head just popped
    ST_WAIT  = 2'd1,  // head present and losing to the ALU
    ST_STALL = 2'd2   // ALU held for one cycle so the head can drain
  } starve_state_t;

endpackage : riscv_wb_pkg

// File: rtl/riscv_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// riscv_wb_arbiter_if
// Bundles every pipeline-facing signal of the writeback arbiter.
//   ALU stream   : alu_valid, alu_rd, alu_data  -> alu_stall
//   LSU stream   : lsu_valid, lsu_rd, lsu_data  -> lsu_ready
//   Issue        : issue_valid, issue_rd        -> busy_mask
//   Regfile port : wb_we, wb_wa, wb_wd (we3/wa3/wd3), fifo_count
//   Bypass       : fwd_valid, fwd_rd, fwd_data (only with RISCV_WB_BYPASS_EN)
// Modports: slave = arbiter side, master = pipeline side.
// FIFO_DEPTH must match the arbiter instance (sizes fifo_count).
// ----------------------------------------------------------------------------
interface riscv_wb_arbiter_if #(
  parameter int FIFO_DEPTH = 4
) ();
  import riscv_wb_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                alu_valid;
  logic [REG_AW-1:0]   alu_rd;
  logic [XLEN-1:0]     alu_data;
  logic                alu_stall;

  logic                lsu_valid;
  logic                lsu_ready;
  logic [REG_AW-1:0]   lsu_rd;
  logic [XLEN-1:0]     lsu_data;

  logic                issue_valid;
  logic [REG_AW-1:0]   issue_rd;
  logic [NUM_REGS-1:0] busy_mask;

  logic                wb_we;
  logic [REG_AW-1:0]   wb_wa;
  logic [XLEN-1:0]     wb_wd;
  logic [CNT_W-1:0]    fifo_count;

`ifdef RISCV_WB_BYPASS_EN
  logic                fwd_valid;
  logic [REG_AW-1:0]   fwd_rd;
  logic [XLEN-1:0]     fwd_data;
`endif

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_stall,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  issue_valid, issue_rd,
    output busy_mask,
    output wb_we, wb_wa, wb_wd, fifo_count
`ifdef RISCV_WB_BYPASS_EN
    ,
    output fwd_valid, fwd_rd, fwd_data
`endif
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_stall,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output issue_valid, issue_rd,
    input  busy_mask,
    input  wb_we, wb_wa, wb_wd, fifo_count
`ifdef RISCV_WB_BYPASS_EN
    ,
    input  fwd_valid, fwd_rd, fwd_data
`endif
  );

endinterface : riscv_wb_arbiter_if

// File: rtl/riscv_wb_fifo.sv
// ----------------------------------------------------------------------------
// riscv_wb_fifo
// Small synchronous FIFO of wb_entry_t with a combinational head view so the
// arbiter can decide on the head in the cycle it becomes visible.
//   clk, rst_n    clock, asynchronous active-low reset (pointers/count only)
//   push, push_data  write side; ignored while full
//   pop, head        read side; head is valid while !empty; pop ignored if empty
//   count, full, empty  occupancy status
// DEPTH must be a power of two >= 2 (pointers wrap naturally).
// ----------------------------------------------------------------------------
module riscv_wb_fifo
  import riscv_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  wb_entry_t                  push_data,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            push_ok, pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage is not reset: stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule : riscv_wb_fifo

// File: rtl/riscv_wb_arbiter.sv
// ----------------------------------------------------------------------------
// riscv_wb_arbiter
// Merges the single-cycle ALU result stream and the buffered long-latency
// (memory / mul-div) stream onto the one regfile write port, and keeps a
// pending-destination scoreboard for hazard stalls at issue.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         riscv_wb_arbiter_if.slave (ALU/LSU/issue inputs, alu_stall,
//               lsu_ready, busy_mask, registered wb_we/wb_wa/wb_wd,
//               fifo_count, optional fwd_*)
// Parameters: FIFO_DEPTH (power of two >= 2), STARVE_LIMIT (>= 2).
// XLEN / REG_AW come from riscv_wb_pkg.
// Optional: define RISCV_WB_BYPASS_EN to drive fwd_valid/fwd_rd/fwd_data,
// copies of the write port used by decode to bypass the same-edge write.
// ----------------------------------------------------------------------------
module riscv_wb_arbiter
  import riscv_wb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  riscv_wb_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT) + 1;

  wb_entry_t           lsu_entry, head;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    count;
  logic                push, pop, alu_take, head_wr;

  starve_state_t       state_reg, state_next;
  logic [SC_W-1:0]     starve_reg, starve_next;
  logic                alu_stall_reg, alu_stall_next;

  logic                wb_we_reg, wb_we_next;
  logic [REG_AW-1:0]   wb_wa_reg, wb_wa_next;
  logic [XLEN-1:0]     wb_wd_reg, wb_wd_next;
  logic [NUM_REGS-1:0] busy_reg, busy_next;

  // ALU wins unless held or targeting x0; an x0 request is consumed without
  // a write, which frees the port for the FIFO head in the same cycle.
  assign alu_take = !alu_stall_reg && bus.alu_valid && (bus.alu_rd != '0);
  assign pop      = !fifo_empty && !alu_take;
  assign head_wr  = pop && (head.rd != '0);
  assign push     = bus.lsu_valid && !fifo_full;

  assign lsu_entry.rd   = bus.lsu_rd;
  assign lsu_entry.data = bus.lsu_data;

  riscv_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (lsu_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Write-port selection; address/data hold when nothing is written.
  always_comb begin
    wb_we_next = 1'b0;
    wb_wa_next = wb_wa_reg;
    wb_wd_next = wb_wd_reg;
    if (alu_take) begin
      wb_we_next = 1'b1;
      wb_wa_next = bus.alu_rd;
      wb_wd_next = bus.alu_data;
    end else if (head_wr) begin
      wb_we_next = 1'b1;
      wb_wa_next = head.rd;
      wb_wd_next = head.data;
    end
  end

  // Scoreboard: a same-cycle set beats the clear (a new op re-targets rd
  // while the old result drains). Bit 0 is tied low.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign busy_next[gi] = 1'b0;
      end else begin : g_xr
        logic set_hit, clr_hit;
        assign set_hit = bus.issue_valid && (bus.issue_rd == REG_AW'(gi));
        assign clr_hit = head_wr && (head.rd == REG_AW'(gi));
        assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
      end
    end
  endgenerate

  // Starve FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      starve_reg    <= '0;
      alu_stall_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      starve_reg    <= starve_next;
      alu_stall_reg <= alu_stall_next;
    end
  end

  // Starve FSM: next state. The counter counts cycles the head has waited;
  // the STALL cycle always pops, because the ALU is ignored and the FIFO
  // cannot have emptied without a pop.
  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    if (pop)              starve_next = '0;
    else if (!fifo_empty) starve_next = starve_reg + SC_W'(1);
    case (state_reg)
      ST_IDLE:  if (!fifo_empty && !pop) state_next = ST_WAIT;
      ST_WAIT: begin
        if (pop)                                        state_next = ST_IDLE;
        else if (starve_reg == SC_W'(STARVE_LIMIT - 1)) state_next = ST_STALL;
      end
      ST_STALL: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Starve FSM: output (registered alu_stall follows the entered state).
  always_comb begin
    alu_stall_next = (state_next == ST_STALL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_reg <= 1'b0;
      wb_wa_reg <= '0;
      wb_wd_reg <= '0;
      busy_reg  <= '0;
    end else begin
      wb_we_reg <= wb_we_next;
      wb_wa_reg <= wb_wa_next;
      wb_wd_reg <= wb_wd_next;
      busy_reg  <= busy_next;
    end
  end

  assign bus.wb_we      = wb_we_reg;
  assign bus.wb_wa      = wb_wa_reg;
  assign bus.wb_wd      = wb_wd_reg;
  assign bus.alu_stall  = alu_stall_reg;
  assign bus.busy_mask  = busy_reg;
  assign bus.fifo_count = count;
  assign bus.lsu_ready  = !fifo_full;

`ifdef RISCV_WB_BYPASS_EN
  assign bus.fwd_valid = wb_we_reg;
  assign bus.fwd_rd    = wb_wa_reg;
  assign bus.fwd_data  = wb_wd_reg;
`endif

endmodule : riscv_wb_arbiter

// File: doc/riscv_wb_arbiter.md
Name: riscv_wb_arbiter

Overview:
- Writer-side front end for the core's 2-read/1-write register file.
- Merges two writeback sources onto the single regfile write port:
  - a single-cycle ALU result stream, which is never back-pressured;
  - a long-latency memory/mul-div result stream, buffered in a small FIFO.
- Keeps a pending-destination scoreboard so issue logic can stall on RAW/WAW hazards against outstanding long-latency ops.
- Registered outputs drive the regfile write port directly (we3/wa3/wd3).

Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register address width (2**REG_AW architectural registers).
- FIFO_DEPTH, 4, long-latency result buffer depth; power of two, >= 2.
- STARVE_LIMIT, 8, consecutive cycles the FIFO head may wait before the ALU is stalled.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  REG_AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_stall  out  1  registered; while 1 the ALU pipe must hold, and alu_valid is ignored.
- lsu_valid  in  1  long-latency result offered.
- lsu_ready  out  1  FIFO not full; a transfer occurs when lsu_valid && lsu_ready.
- lsu_rd  in  REG_AW  long-latency destination register.
- lsu_data  in  XLEN  long-latency result.
- issue_valid  in  1  a long-latency op is issued this cycle.
- issue_rd  in  REG_AW  its destination register.
- busy_mask  out  2**REG_AW  scoreboard; bit r = 1 means a write to register r is pending.
- wb_we  out  1  to regfile we3.
- wb_wa  out  REG_AW  to regfile wa3.
- wb_wd  out  XLEN  to regfile wd3.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - wb_we=0, wb_wa=0, wb_wd=0, alu_stall=0, busy_mask=0, fifo_count=0;
  - FIFO pointers cleared and starve counter=0;
  - any in-flight entries are discarded.
- Latency:
  - accepted inputs appear on wb_* exactly 1 cycle later for the ALU path;
  - the FIFO path takes 1 cycle at minimum from head selection;
  - a FIFO write followed by a pop of that entry takes at least 2 cycles from lsu handshake to wb_we.
- Arbitration, evaluated each cycle:
  - if alu_stall=0 and alu_valid=1 and alu_rd!=0, the ALU wins;
  - otherwise, if the FIFO is non-empty, pop the head: it is written if its rd!=0, and silently dropped if rd==0;
  - otherwise wb_we=0.
  - wb_wa/wb_wd hold their last values when wb_we=0.
- x0 handling: ALU requests with rd==0 are consumed with no write, and the FIFO may drain in that same cycle.
- lsu_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
  - A push and a pop in the same cycle while full is not allowed, because ready is already 0.
  - A push and a pop while non-full leaves the count unchanged.
- Starvation control:
  - the starve counter increments each cycle the FIFO is non-empty and no pop occurs, and clears on any pop;
  - when it reaches STARVE_LIMIT-1, alu_stall is set at the next edge;
  - alu_stall clears on the edge after the first pop it enables, so it is high for exactly one cycle per starvation event.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets busy[issue_rd];
  - a FIFO pop with rd!=0 clears busy[rd];
  - setting and clearing the same bit in one cycle leaves it set;
  - busy[0] is always 0.
- Ordering:
  - WAW between sources is prevented upstream: issue stalls while busy[rd] is set, so the ALU never targets a busy register;
  - results are not reordered inside the FIFO.
- Single state machine (starve control): IDLE -> WAIT (FIFO non-empty and not popped) -> STALL (limit reached) -> IDLE (after the forced pop).

Optional Feature:
- Macro: RISCV_WB_BYPASS_EN.
- With the macro defined:
  - extra outputs fwd_valid (1), fwd_rd (REG_AW), fwd_data (XLEN) mirror wb_we/wb_wa/wb_wd;
  - the decode stage uses them to bypass the same-edge write, since regfile reads are combinational and return the old value.
- Without the macro: these ports do not exist and no extra logic is built.

Decomposition:
- Package riscv_wb_pkg holds:
  - XLEN and REG_AW constants;
  - the wb_entry_t struct {rd, data};
  - the starve-FSM state enum.
- Sub-module riscv_wb_fifo: synchronous FIFO of wb_entry_t with push/pop/count/full/empty, async active-low reset.

Test Plan:
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF -> next cycle wb_we=1, wb_wa=5, wb_wd=0xDEADBEEF.
- Scoreboard round trip: issue rd=7 -> busy_mask[7]=1. Then lsu push rd=7, data=0x1234 with ALU idle -> wb write to x7 two cycles later, and busy_mask[7]=0 on the same edge.
- Full FIFO: 4 lsu pushes while the ALU is continuously valid -> lsu_ready=0 after the 4th push, fifo_count=4, and no 5th push is accepted.
- Starvation: FIFO holds 1 entry and the ALU is valid every cycle -> alu_stall=1 in the 9th cycle, FIFO head is written in that cycle's writeback, and alu_stall=0 on the next cycle.
- x0: ALU rd=0 with FIFO head rd=3 in the same cycle -> no ALU write, and x3 is written the next cycle. FIFO head rd=0 -> popped, with wb_we=0.
- Reset mid-drain: rst_n=0 while fifo_count=3 and busy_mask=0x88 -> all outputs 0 immediately, with no wb_we after release.
